// File: rtl/sync_edge_debouncer.sv
// -----------------------------------------------------------------------------
// sync_edge_debouncer
//
// Debounces an already-synchronized level in the fast_clk domain. A change is
// accepted only after the input has differed from the debounced level for
// STABLE_CYCLES consecutive edges. Every accepted change yields a one-cycle
// rise/fall pulse, a saturating rising-edge count and a one-entry valid/ready
// event record with a sticky overflow flag.
//
// Parameters:
//   STABLE_CYCLES  consecutive differing samples needed to accept (1..255)
//   CNT_WIDTH      width of edge_count (1..32)
//
// Ports:
//   fast_clk       in   clock, all logic on the rising edge
//   rst            in   synchronous active-high reset
//   sync_in        in   synchronized input level
//   clear_cnt      in   synchronous clear of edge_count and overflow
//   event_ready    in   consumer accepts the held event record
//   level_out      out  debounced level
//   rise_pulse     out  one-cycle pulse on an accepted 0->1 change
//   fall_pulse     out  one-cycle pulse on an accepted 1->0 change
//   edge_count     out  saturating count of accepted rising edges
//   event_valid    out  event record held for the consumer
//   event_is_rise  out  type of the held event (1 = rise, 0 = fall)
//   overflow       out  sticky: an event was dropped while the record was full
// -----------------------------------------------------------------------------
module sync_edge_debouncer #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_WIDTH     = 8
) (
   input  logic                 fast_clk,
   input  logic                 rst,
   input  logic                 sync_in,
   input  logic                 clear_cnt,
   input  logic                 event_ready,
   output logic                 level_out,
   output logic                 rise_pulse,
   output logic                 fall_pulse,
   output logic [CNT_WIDTH-1:0] edge_count,
   output logic                 event_valid,
   output logic                 event_is_rise,
   output logic                 overflow
);

   localparam int unsigned        SW       = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0]      LAST_CNT = SW'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_STABLE_LOW  = 2'd0,
      ST_PEND_HIGH   = 2'd1,
      ST_STABLE_HIGH = 2'd2,
      ST_PEND_LOW    = 2'd3
   } state_t;

   state_t          state_r;
   logic [SW-1:0]   stable_cnt_r;
   logic            cur_level_s;
   logic            accept_s;
   logic            accept_rise_s;
   logic            accept_fall_s;
   logic            new_event_s;
   logic            drop_s;

   // Decode the current debounced level from the FSM state and detect acceptance.
   always_comb begin
      cur_level_s = 1'b0;
      case (state_r)
         ST_STABLE_LOW:  cur_level_s = 1'b0;
         ST_PEND_HIGH:   cur_level_s = 1'b0;
         ST_STABLE_HIGH: cur_level_s = 1'b1;
         ST_PEND_LOW:    cur_level_s = 1'b1;
         default:        cur_level_s = 1'b0;
      endcase
      accept_s      = (sync_in != cur_level_s) && (stable_cnt_r == LAST_CNT);
      accept_rise_s = accept_s & sync_in;
      accept_fall_s = accept_s & ~sync_in;
      new_event_s   = accept_rise_s | accept_fall_s;
      // A new event is lost only when the held record is not being consumed.
      drop_s        = new_event_s & event_valid & ~event_ready;
   end

   // Debounce FSM with registered level and edge pulses.
   always_ff @(posedge fast_clk) begin
      if (rst) begin
         state_r      <= ST_STABLE_LOW;
         stable_cnt_r <= '0;
         level_out    <= 1'b0;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
      end else begin
         rise_pulse <= accept_rise_s;
         fall_pulse <= accept_fall_s;
         if (sync_in == cur_level_s) begin
            // Input agrees with the debounced level: discard any partial run.
            stable_cnt_r <= '0;
            state_r      <= cur_level_s ? ST_STABLE_HIGH : ST_STABLE_LOW;
         end else if (accept_s) begin
            stable_cnt_r <= '0;
            level_out    <= sync_in;
            state_r      <= sync_in ? ST_STABLE_HIGH : ST_STABLE_LOW;
         end else begin
            stable_cnt_r <= stable_cnt_r + SW'(1);
            state_r      <= cur_level_s ? ST_PEND_LOW : ST_PEND_HIGH;
         end
      end
   end

   // Saturating count of accepted rising edges; clear is applied before the increment.
   always_ff @(posedge fast_clk) begin
      if (rst) begin
         edge_count <= '0;
      end else if (accept_rise_s) begin
         if (clear_cnt) begin
            edge_count <= CNT_WIDTH'(1);
         end else if (edge_count == CNT_MAX) begin
            edge_count <= CNT_MAX;
         end else begin
            edge_count <= edge_count + CNT_WIDTH'(1);
         end
      end else if (clear_cnt) begin
         edge_count <= '0;
      end else begin
         edge_count <= edge_count;
      end
   end

   // One-entry event record with valid/ready handshake and sticky overflow.
   always_ff @(posedge fast_clk) begin
      if (rst) begin
         event_valid   <= 1'b0;
         event_is_rise <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         if (new_event_s && !drop_s) begin
            event_valid   <= 1'b1;
            event_is_rise <= accept_rise_s;
         end else if (!new_event_s && event_valid && event_ready) begin
            event_valid   <= 1'b0;
         end else begin
            event_valid   <= event_valid;
         end
         // A drop in the same cycle as a clear leaves the flag set.
         if (drop_s) begin
            overflow <= 1'b1;
         end else if (clear_cnt) begin
            overflow <= 1'b0;
         end else begin
            overflow <= overflow;
         end
      end
   end

endmodule

// File: tb/tb_sync_edge_debouncer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for sync_edge_debouncer. Three instances with different
// parameters share the same stimulus; each is compared every cycle against a
// reference that accepts a change when the last N input samples since reset
// all differ from the current debounced level.
// -----------------------------------------------------------------------------
module tb_sync_edge_debouncer;

   logic fast_clk = 1'b0;
   logic rst = 1'b1;
   logic sync_in = 1'b0;
   logic clear_cnt = 1'b0;
   logic event_ready = 1'b0;

   logic       lvl_o [3];
   logic       rise_o [3];
   logic       fall_o [3];
   logic       ev_o [3];
   logic       evr_o [3];
   logic       ovf_o [3];
   logic [7:0] cnt0;
   logic [1:0] cnt1;
   logic [7:0] cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int unsigned m_n [3] = '{4, 4, 1};
   int unsigned m_w [3] = '{8, 2, 8};
   bit          samples [$];
   bit          e_lvl [3];
   bit          e_rise [3];
   bit          e_fall [3];
   int unsigned e_cnt [3];
   bit          e_valid [3];
   bit          e_isr [3];
   bit          e_ovf [3];

   always #5 fast_clk = ~fast_clk;

   sync_edge_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) u0 (
      .fast_clk(fast_clk), .rst(rst), .sync_in(sync_in), .clear_cnt(clear_cnt),
      .event_ready(event_ready), .level_out(lvl_o[0]), .rise_pulse(rise_o[0]),
      .fall_pulse(fall_o[0]), .edge_count(cnt0), .event_valid(ev_o[0]),
      .event_is_rise(evr_o[0]), .overflow(ovf_o[0]));

   sync_edge_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(2)) u1 (
      .fast_clk(fast_clk), .rst(rst), .sync_in(sync_in), .clear_cnt(clear_cnt),
      .event_ready(event_ready), .level_out(lvl_o[1]), .rise_pulse(rise_o[1]),
      .fall_pulse(fall_o[1]), .edge_count(cnt1), .event_valid(ev_o[1]),
      .event_is_rise(evr_o[1]), .overflow(ovf_o[1]));

   sync_edge_debouncer #(.STABLE_CYCLES(1), .CNT_WIDTH(8)) u2 (
      .fast_clk(fast_clk), .rst(rst), .sync_in(sync_in), .clear_cnt(clear_cnt),
      .event_ready(event_ready), .level_out(lvl_o[2]), .rise_pulse(rise_o[2]),
      .fall_pulse(fall_o[2]), .edge_count(cnt2), .event_valid(ev_o[2]),
      .event_is_rise(evr_o[2]), .overflow(ovf_o[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit accepted(input int i);
      if (samples.size() < m_n[i]) return 1'b0;
      for (int k = 0; k < int'(m_n[i]); k++) begin
         if (samples[samples.size() - 1 - k] == e_lvl[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Advance the reference by one clock edge using the inputs sampled on it.
   task automatic model_edge(input bit r, input bit s, input bit clr, input bit rdy);
      bit acc, nev, drop;
      int unsigned cmax;
      if (r) begin
         samples.delete();
         for (int i = 0; i < 3; i++) begin
            e_lvl[i] = 0; e_rise[i] = 0; e_fall[i] = 0; e_cnt[i] = 0;
            e_valid[i] = 0; e_isr[i] = 0; e_ovf[i] = 0;
         end
         return;
      end
      samples.push_back(s);
      if (samples.size() > 8) void'(samples.pop_front());
      for (int i = 0; i < 3; i++) begin
         acc       = accepted(i);
         e_rise[i] = acc && s;
         e_fall[i] = acc && !s;
         if (acc) e_lvl[i] = s;
         cmax = (1 << m_w[i]) - 1;
         if (e_rise[i]) e_cnt[i] = clr ? 1 : ((e_cnt[i] == cmax) ? cmax : e_cnt[i] + 1);
         else if (clr) e_cnt[i] = 0;
         nev  = e_rise[i] || e_fall[i];
         drop = nev && e_valid[i] && !rdy;
         if (nev && !drop) begin
            e_valid[i] = 1;
            e_isr[i]   = e_rise[i];
         end else if (!nev && e_valid[i] && rdy) begin
            e_valid[i] = 0;
         end
         if (drop) e_ovf[i] = 1;
         else if (clr) e_ovf[i] = 0;
      end
   endtask

   task automatic check_all();
      logic [31:0] c;
      for (int i = 0; i < 3; i++) begin
         c = (i == 0) ? 32'(cnt0) : (i == 1) ? 32'(cnt1) : 32'(cnt2);
         check($sformatf("u%0d.level", i), 32'(lvl_o[i]), 32'(e_lvl[i]));
         check($sformatf("u%0d.rise", i), 32'(rise_o[i]), 32'(e_rise[i]));
         check($sformatf("u%0d.fall", i), 32'(fall_o[i]), 32'(e_fall[i]));
         check($sformatf("u%0d.count", i), c, 32'(e_cnt[i]));
         check($sformatf("u%0d.valid", i), 32'(ev_o[i]), 32'(e_valid[i]));
         if (e_valid[i]) check($sformatf("u%0d.is_rise", i), 32'(evr_o[i]), 32'(e_isr[i]));
         check($sformatf("u%0d.overflow", i), 32'(ovf_o[i]), 32'(e_ovf[i]));
      end
   endtask

   // Drive one cycle of inputs, clock it, update the reference, then compare.
   task automatic cycle(input bit r, input bit s, input bit clr, input bit rdy);
      rst = r; sync_in = s; clear_cnt = clr; event_ready = rdy;
      @(posedge fast_clk);
      model_edge(r, s, clr, rdy);
      @(negedge fast_clk);
      check_all();
   endtask

   initial begin
      int len;
      bit lvl;
      @(negedge fast_clk);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      // rise held with consumer stalled, then a fall that gets dropped
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      // short high glitch
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      // five accepted rises to saturate the narrow counter
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
         for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      end
      // clear coinciding with an accepted rise
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      // reset during a pending rise
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      // toggle every cycle with the consumer always ready
      for (int k = 0; k < 20; k++) cycle(1'b0, k[0], 1'b0, 1'b1);
      // randomized runs
      lvl = 1'b0;
      for (int r = 0; r < 600; r++) begin
         lvl = ~lvl;
         len = $urandom_range(1, 7);
         for (int k = 0; k < len; k++) begin
            cycle(($urandom_range(0, 199) == 0), lvl, ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 2) != 0));
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
